my_press_classifier: RTL and testbench

- Consumes the single-cycle press pulse and the synchronised button level from the debounced single-pulse stage.
- Classifies each user action as a short press, a long press or a double press.
- Emits exactly one one-cycle pulse per action, on one of three outputs.
- Sits between the button front-end and the menu/mode control logic, and runs on the same slow sampling clock as the debounce stage.

---
 rtl/my_press_classifier.sv | 149 ++++++++++++++
 tb/tb_my_press_classifier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_press_classifier.sv
// my_press_classifier
// Turns the debounced press pulse and the synchronised button level into one
// of three single-cycle action pulses: short press, long press, double press.
// A short press is only reported once the double-press window has expired, so
// its pulse lags the release by the length of that window.

module my_press_classifier #(
   parameter int LONG_CYCLES = 100,  // held cycles after the press that make a long press
   parameter int GAP_CYCLES  = 30,   // cycles after release that still accept a second press
   parameter int CNT_WIDTH   = 8     // must hold max(LONG_CYCLES, GAP_CYCLES)
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       press_pulse,
   input  logic       button_level,
   output logic       short_press,
   output logic       long_press,
   output logic       double_press,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // State encodings are visible on state_dbg, so they are fixed explicitly.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HELD1     = 3'd1,
      ST_WAIT2     = 3'd2,
      ST_LONG_HOLD = 3'd3,
      ST_WAIT_REL  = 3'd4
   } state_e;

   // Compare values are the last count before the event, so cnt never has to
   // reach LONG_CYCLES or GAP_CYCLES itself and can never wrap.
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e               state_q;
   state_e               state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 short_q;
   logic                 short_d;
   logic                 long_q;
   logic                 long_d;
   logic                 double_q;
   logic                 double_d;
   logic                 busy_q;
   logic                 busy_d;

   // Next-state, counter and pulse decode; pulses default low so each lasts one cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The level is not checked here: a pulse with the level already
            // low still starts an action, and HELD1 sees the release next edge.
            if (press_pulse) begin
               state_d = ST_HELD1;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_HELD1: begin
            if (!button_level) begin
               state_d = ST_WAIT2;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == LONG_LAST) begin
               state_d = ST_LONG_HOLD;
               long_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         ST_LONG_HOLD: begin
            // Long press already reported; just wait out the hold.
            if (!button_level) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LONG_HOLD;
            end
         end

         ST_WAIT2: begin
            // A press on the timeout edge still counts as a double press.
            if (press_pulse) begin
               state_d  = ST_WAIT_REL;
               double_d = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               state_d  = ST_IDLE;
               short_d  = 1'b1;
            end else begin
               cnt_d    = cnt_q + CNT_ONE;
            end
         end

         ST_WAIT_REL: begin
            // Second press of a double: however long it is held, no long press.
            if (!button_level) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_REL;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and all outputs are registered together; reset abandons any action.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= CNT_ZERO;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         busy_q   <= busy_d;
      end
   end

   assign short_press  = short_q;
   assign long_press   = long_q;
   assign double_press = double_q;
   assign busy         = busy_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_my_press_classifier.sv
// Self-checking bench for my_press_classifier (LONG_CYCLES=4, GAP_CYCLES=3).
// Stimulus is built as a timeline of user actions; expected outputs for every
// edge are derived from each action's timing with interval arithmetic.

module tb_my_press_classifier;

   localparam int LONG = 4;
   localparam int GAP  = 3;
   localparam int MAXT = 1600;

   logic       clock;
   logic       reset_n;
   logic       press_pulse;
   logic       button_level;
   logic       short_press;
   logic       long_press;
   logic       double_press;
   logic       busy;
   logic [2:0] state_dbg;

   int compared   = 0;
   int mismatched = 0;

   // Timeline: stimulus applied before edge t, expectation observed after edge t.
   bit       s_pp  [MAXT];
   bit       s_lvl [MAXT];
   bit       e_sh  [MAXT];
   bit       e_lg  [MAXT];
   bit       e_db  [MAXT];
   bit [2:0] e_st  [MAXT];

   my_press_classifier #(
      .LONG_CYCLES(LONG),
      .GAP_CYCLES (GAP),
      .CNT_WIDTH  (8)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .press_pulse (press_pulse),
      .button_level(button_level),
      .short_press (short_press),
      .long_press  (long_press),
      .double_press(double_press),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clear_sched();
      for (int i = 0; i < MAXT; i++) begin
         s_pp[i] = 1'b0; s_lvl[i] = 1'b0;
         e_sh[i] = 1'b0; e_lg[i] = 1'b0; e_db[i] = 1'b0; e_st[i] = 3'd0;
      end
   endtask

   task automatic rand_extras(input int lo, input int hi, input bit en);
      if (en) begin
         for (int t = lo; t <= hi; t++) begin
            if ($urandom_range(0, 3) == 0) s_pp[t] = 1'b1;
         end
      end
   endtask

   // One action: press at edge p, level high for h edges (p..p+h-1).
   // k in 1..GAP places a second press k edges after the release edge, held h2.
   // Returns e, the edge after which the classifier is idle again.
   task automatic add_action(input int p, input int h, input int k, input int h2,
                             input bit extras, output int e);
      int r;
      int q;
      s_pp[p] = 1'b1;
      for (int t = p; t < p + h; t++) s_lvl[t] = 1'b1;
      if (h > LONG) begin
         // level still high at edge p+LONG -> long press
         for (int t = p; t < p + LONG; t++) e_st[t] = 3'd1;
         for (int t = p + LONG; t < p + h; t++) e_st[t] = 3'd3;
         e_lg[p + LONG] = 1'b1;
         e = p + h;
         rand_extras(p + 1, e, extras);
      end else begin
         r = p + ((h == 0) ? 1 : h);
         for (int t = p; t < r; t++) e_st[t] = 3'd1;
         rand_extras(p + 1, r, extras);
         if (k >= 1 && k <= GAP) begin
            q = r + k;
            for (int t = r; t < q; t++) e_st[t] = 3'd2;
            s_pp[q] = 1'b1;
            e_db[q] = 1'b1;
            for (int t = q; t < q + h2; t++) s_lvl[t] = 1'b1;
            e = q + ((h2 == 0) ? 1 : h2);
            for (int t = q; t < e; t++) e_st[t] = 3'd4;
            rand_extras(q + 1, e, extras);
         end else begin
            e = r + GAP;
            for (int t = r; t < e; t++) e_st[t] = 3'd2;
            e_sh[e] = 1'b1;
         end
      end
   endtask

   task automatic run_sched(input string name, input int n);
      logic [6:0] exp_v;
      logic [6:0] act_v;
      for (int t = 0; t < n; t++) begin
         @(negedge clock);
         press_pulse  = s_pp[t];
         button_level = s_lvl[t];
         @(posedge clock);
         #1;
         exp_v = {e_sh[t], e_lg[t], e_db[t], (e_st[t] != 3'd0), e_st[t]};
         act_v = {short_press, long_press, double_press, busy, state_dbg};
         compared++;
         if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL %s edge=%0d got sh/lg/db/busy/st=%b required %b", name, t, act_v, exp_v);
         end
      end
      @(negedge clock);
      press_pulse  = 1'b0;
      button_level = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] act_v;
      reset_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         press_pulse  = 1'($urandom_range(0, 1));
         button_level = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         act_v = {short_press, long_press, double_press, busy, state_dbg};
         compared++;
         if (act_v !== 7'd0) begin
            mismatched++;
            $display("FAIL reset_hold cyc=%0d got %b required 0000000", i, act_v);
         end
      end
      @(negedge clock);
      press_pulse  = 1'b0;
      button_level = 1'b0;
      #2;
      reset_n = 1'b1;
      clear_sched();
      run_sched("reset_release", 4);
   endtask

   task automatic test_short();
      int e;
      clear_sched();
      add_action(0, 2, 0, 0, 1'b0, e);
      run_sched("short", e + 3);
   endtask

   task automatic test_long();
      int e;
      clear_sched();
      add_action(0, 10, 0, 0, 1'b0, e);
      run_sched("long", e + 3);
   endtask

   task automatic test_double();
      int e;
      clear_sched();
      add_action(0, 2, 2, 10, 1'b0, e);
      run_sched("double", e + 3);
   endtask

   task automatic test_simultaneous();
      int e;
      clear_sched();
      add_action(0, 2, GAP, 1, 1'b0, e);
      run_sched("timeout_and_press", e + 3);
   endtask

   task automatic test_ignored_abort();
      int e;
      logic [6:0] act_v;
      clear_sched();
      add_action(0, 8, 0, 0, 1'b0, e);
      s_pp[2] = 1'b1;          // during HELD1
      s_pp[6] = 1'b1;          // during LONG_HOLD
      s_pp[7] = 1'b1;
      run_sched("ignored_pulses", e + 3);
      // abort from WAIT2: edges 0..3 put the DUT in WAIT2 with the timeout pending
      clear_sched();
      add_action(0, 2, 0, 0, 1'b0, e);
      run_sched("abort_pre", 4);
      #2;
      reset_n = 1'b0;
      #1;
      act_v = {short_press, long_press, double_press, busy, state_dbg};
      compared++;
      if (act_v !== 7'd0) begin
         mismatched++;
         $display("FAIL abort_async got %b required 0000000", act_v);
      end
      @(negedge clock);
      reset_n = 1'b1;
      clear_sched();
      run_sched("abort_post", 8);
   endtask

   task automatic test_random();
      int t;
      int e;
      clear_sched();
      t = 0;
      while (t < 1500) begin
         add_action(t, $urandom_range(0, LONG + 3), $urandom_range(0, GAP + 2),
                    $urandom_range(0, LONG + 4), 1'b1, e);
         t = e + 1 + $urandom_range(0, 3);
      end
      run_sched("random", t + 3);
   endtask

   initial begin
      reset_n      = 1'b0;
      press_pulse  = 1'b0;
      button_level = 1'b0;
      test_reset();
      test_short();
      test_long();
      test_double();
      test_simultaneous();
      test_ignored_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
